// File: rtl/pixel_writeback.sv
// rtl/pixel_writeback.sv - streams a run of shader lane outputs to the framebuffer over an Avalon-MM write master
module pixel_writeback #(
    parameter int H_RESOLUTION = 320,
    parameter int V_RESOLUTION = 240,
    parameter int NUM_LANES    = 320,
    parameter int PIXEL_BITS   = 16,
    parameter int SKIP_EN      = 1,
    localparam int COL_BITS    = $clog2(H_RESOLUTION),
    localparam int ROW_BITS    = $clog2(V_RESOLUTION),
    localparam int LANE_BITS   = $clog2(NUM_LANES + 1)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [31:0]                     base_addr,
    input  logic [ROW_BITS-1:0]             start_row,
    input  logic [COL_BITS-1:0]             start_col,
    input  logic [LANE_BITS-1:0]            count,
    input  logic [PIXEL_BITS-1:0]           transparent,
    input  logic                            skip_mode,
    input  logic [NUM_LANES*PIXEL_BITS-1:0] pixel_data,
    input  logic                            abort,
    input  logic                            clear_error,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [LANE_BITS-1:0]            written,
    output logic [31:0]                     m1_address,
    output logic [PIXEL_BITS-1:0]           m1_writedata,
    output logic                            m1_write,
    input  logic                            m1_waitrequest
);

    localparam int                  BPP_SHIFT = $clog2(PIXEL_BITS / 8);
    localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(V_RESOLUTION - 1);
    localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(H_RESOLUTION - 1);
    localparam logic [31:0]         H_RES32   = 32'(H_RESOLUTION);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE, ST_ERROR} state_t;

    state_t                state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [31:0]           row_base_q, row_base_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [LANE_BITS-1:0]  lane_q, lane_d;
    logic [LANE_BITS-1:0]  count_q, count_d;
    logic [LANE_BITS-1:0]  written_q, written_d;
    logic                  skip_q, skip_d;
    logic                  abort_pend_q, abort_pend_d;
    logic [PIXEL_BITS-1:0] key_q, key_d;

    logic [PIXEL_BITS-1:0] pixel;
    logic                  skip_hit;
    logic [31:0]           pix_index;
    logic [31:0]           addr;

    assign pixel     = pixel_data[32'(lane_q) * PIXEL_BITS +: PIXEL_BITS];
    assign skip_hit  = (SKIP_EN != 0) && skip_q && (pixel == key_q);
    // row_base_q tracks row*H_RESOLUTION incrementally so only an add sits in the address path
    assign pix_index = row_base_q + 32'(col_q);
    assign addr      = base_q + (pix_index << BPP_SHIFT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            row_base_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            lane_q       <= '0;
            count_q      <= '0;
            written_q    <= '0;
            skip_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            key_q        <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            row_base_q   <= row_base_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lane_q       <= lane_d;
            count_q      <= count_d;
            written_q    <= written_d;
            skip_q       <= skip_d;
            abort_pend_q <= abort_pend_d;
            key_q        <= key_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        row_base_d   = row_base_q;
        row_d        = row_q;
        col_d        = col_q;
        lane_d       = lane_q;
        count_d      = count_q;
        written_d    = written_q;
        skip_d       = skip_q;
        abort_pend_d = abort_pend_q;
        key_d        = key_q;
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    base_d     = base_addr;
                    row_d      = start_row;
                    col_d      = start_col;
                    row_base_d = 32'(start_row) * H_RES32;
                    count_d    = count;
                    skip_d     = skip_mode;
                    key_d      = transparent;
                    lane_d     = '0;
                    written_d  = '0;
                    if (start_row > ROW_LAST || start_col > COL_LAST) begin
                        state_d = ST_ERROR;
                    end else if (count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // A lane finishes either on its single skip cycle or when the slave accepts the write
                if (skip_hit || !m1_waitrequest) begin
                    if (!skip_hit) begin
                        written_d = written_q + LANE_BITS'(1);
                    end
                    if (abort || abort_pend_q) begin
                        state_d = ST_DONE;
                    end else if (lane_q + LANE_BITS'(1) == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_d = lane_q + LANE_BITS'(1);
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                state_d = ST_ERROR;
                            end else begin
                                row_d      = row_q + ROW_BITS'(1);
                                row_base_d = row_base_q + H_RES32;
                            end
                        end else begin
                            col_d = col_q + COL_BITS'(1);
                        end
                    end
                end else if (abort) begin
                    abort_pend_d = 1'b1;
                end
            end
            ST_DONE: begin
                abort_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_ERROR: begin
                if (clear_error) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == ST_WRITE);
        done         = (state_q == ST_DONE);
        error        = (state_q == ST_ERROR);
        written      = written_q;
        m1_write     = (state_q == ST_WRITE) && !skip_hit;
        m1_address   = m1_write ? addr : '0;
        m1_writedata = m1_write ? pixel : '0;
    end

endmodule

// File: tb/tb_pixel_writeback.sv
// tb/tb_pixel_writeback.sv - directed self-checking bench for pixel_writeback
module tb_pixel_writeback;

    localparam int NL = 320;
    localparam int PB = 16;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               start;
    logic [31:0]        base_addr;
    logic [7:0]         start_row;
    logic [8:0]         start_col;
    logic [8:0]         count;
    logic [PB-1:0]      transparent;
    logic               skip_mode;
    logic [NL*PB-1:0]   pixel_data;
    logic               abort;
    logic               clear_error;
    logic               busy, done, error;
    logic [8:0]         written;
    logic [31:0]        m1_address;
    logic [PB-1:0]      m1_writedata;
    logic               m1_write;
    logic               m1_waitrequest = 1'b0;

    int checks = 0;
    int failures = 0;

    // slave model state and acceptance log
    logic [31:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];
    int          cycle_n = 0;
    int          stall_left = 0;
    int          stall_viol = 0;
    bit          in_prog = 0;
    logic [31:0] held_addr;
    logic [15:0] held_data;
    bit          rand_mode = 0;
    int          stall_default = 0;
    int          special_idx = -1;
    int          special_len = 0;
    int          run_base = 0;

    pixel_writeback dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .start_row(start_row), .start_col(start_col), .count(count),
        .transparent(transparent), .skip_mode(skip_mode), .pixel_data(pixel_data),
        .abort(abort), .clear_error(clear_error), .busy(busy), .done(done),
        .error(error), .written(written), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest)
    );

    always #5 clock = ~clock;

    // Avalon slave: decides waitrequest for the coming edge and logs the accepting cycle
    always @(negedge clock) begin
        cycle_n++;
        if (!m1_write) begin
            in_prog        = 0;
            m1_waitrequest = 1'b0;
        end else begin
            if (!in_prog) begin
                in_prog   = 1;
                held_addr = m1_address;
                held_data = m1_writedata;
                if (rand_mode)
                    stall_left = $urandom_range(0, 3);
                else if (log_addr.size() - run_base == special_idx)
                    stall_left = special_len;
                else
                    stall_left = stall_default;
            end else if (m1_address !== held_addr || m1_writedata !== held_data) begin
                stall_viol++;
            end
            if (stall_left > 0) begin
                m1_waitrequest = 1'b1;
                stall_left--;
            end else begin
                m1_waitrequest = 1'b0;
                log_addr.push_back(m1_address);
                log_data.push_back(m1_writedata);
                log_cyc.push_back(cycle_n);
                in_prog = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_lanes();
        for (int k = 0; k < NL; k++) pixel_data[k*PB +: PB] = 16'h1000 + 16'(k);
    endtask

    task automatic start_run(input logic [31:0] b, input int r, input int c, input int n,
                             input bit sk, input logic [15:0] key);
        run_base    = log_addr.size();
        base_addr   = b;
        start_row   = 8'(r);
        start_col   = 9'(c);
        count       = 9'(n);
        skip_mode   = sk;
        transparent = key;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic run_until_end(input int budget, output bit saw_done, output bit saw_err);
        saw_done = 0;
        saw_err  = 0;
        for (int i = 0; i < budget && !saw_done && !saw_err; i++) begin
            tick();
            if (done)  saw_done = 1;
            if (error) saw_err  = 1;
        end
    endtask

    initial begin
        bit sd, se;
        int bad_addr, bad_data, n;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; start_row = '0; start_col = '0;
        count = '0; transparent = '0; skip_mode = 1'b0; abort = 1'b0; clear_error = 1'b0;
        pixel_data = '0;
        fill_lanes();
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_written", written, 0);
        check("reset_write", m1_write, 0);
        check("reset_addr", m1_address, 0);
        reset_n = 1'b1;
        tick();

        // single pixel, zero wait
        start_run(32'h0800_0000, 2, 5, 1, 0, 16'h0);
        check("single_busy", busy, 1);
        check("single_write", m1_write, 1);
        check("single_addr", m1_address, 32'h0800_050A);
        check("single_data", m1_writedata, 16'h1000);
        tick();
        check("single_done", done, 1);
        check("single_written", written, 1);
        check("single_nwrites", log_addr.size() - run_base, 1);
        start = 1'b1;                      // start in DONE cycle must be ignored
        tick();
        start = 1'b0;
        check("single_done_pulse", done, 0);
        check("start_in_done_ignored", busy, 0);
        tick();

        // count = 0 goes straight to DONE
        start_run(32'h0, 0, 0, 0, 0, 16'h0);
        check("cnt0_done", done, 1);
        check("cnt0_busy", busy, 0);
        check("cnt0_written", written, 0);
        tick();

        // out-of-range start row
        start_run(32'h0, 240, 0, 3, 0, 16'h0);
        check("badrow_error", error, 1);
        check("badrow_write", m1_write, 0);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("badrow_cleared", error, 0);

        // full run with random stalls; a stray start mid-run must not disturb it
        rand_mode = 1;
        start_run(32'h1000_0000, 0, 0, 320, 0, 16'h0);
        repeat (5) tick();
        base_addr = 32'hDEAD_0000; start_row = 8'd5; count = 9'd1; start = 1'b1;
        tick();
        start = 1'b0;
        run_until_end(2000, sd, se);
        check("full_done", sd, 1);
        check("full_written", written, 320);
        check("full_nwrites", log_addr.size() - run_base, 320);
        bad_addr = 0; bad_data = 0;
        n = log_addr.size() - run_base;
        for (int k = 0; k < n && k < 320; k++) begin
            if (log_addr[run_base+k] !== 32'h1000_0000 + 32'(2*k)) bad_addr++;
            if (log_data[run_base+k] !== 16'h1000 + 16'(k)) bad_data++;
        end
        check("full_addr_seq", bad_addr, 0);
        check("full_data_seq", bad_data, 0);
        check("full_stall_stable", stall_viol, 0);
        rand_mode = 0;
        tick();

        // row wrap
        start_run(32'h0, 0, 318, 4, 0, 16'h0);
        run_until_end(20, sd, se);
        check("wrap_done", sd, 1);
        check("wrap_nwrites", log_addr.size() - run_base, 4);
        check("wrap_a0", log_addr[run_base+0], 32'h27C);
        check("wrap_a1", log_addr[run_base+1], 32'h27E);
        check("wrap_a2", log_addr[run_base+2], 32'h280);
        check("wrap_a3", log_addr[run_base+3], 32'h282);
        tick();

        // end-of-frame overrun
        start_run(32'h0, 239, 318, 4, 0, 16'h0);
        run_until_end(20, sd, se);
        check("ovr_error", se, 1);
        check("ovr_no_done", sd, 0);
        check("ovr_nwrites", log_addr.size() - run_base, 2);
        check("ovr_a0", log_addr[run_base+0], 32'd153596);
        check("ovr_a1", log_addr[run_base+1], 32'd153598);
        check("ovr_written", written, 2);
        tick();
        check("ovr_sticky", error, 1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("ovr_cleared", error, 0);

        // transparent skip on lanes 1 and 3
        pixel_data[1*PB +: PB] = 16'hF81F;
        pixel_data[3*PB +: PB] = 16'hF81F;
        start_run(32'h0, 0, 0, 5, 1, 16'hF81F);
        run_until_end(20, sd, se);
        check("skip_done", sd, 1);
        check("skip_written", written, 3);
        check("skip_nwrites", log_addr.size() - run_base, 3);
        check("skip_d1", log_data[run_base+1], 16'h1002);
        check("skip_a2", log_addr[run_base+2], 32'h8);
        check("skip_gap1", log_cyc[run_base+1] - log_cyc[run_base+0], 2);
        check("skip_gap2", log_cyc[run_base+2] - log_cyc[run_base+1], 2);
        fill_lanes();
        tick();

        // abort during a 5-cycle stall on lane 10
        special_idx = 10; special_len = 5;
        start_run(32'h0, 0, 0, 20, 0, 16'h0);
        sd = 0;
        for (int i = 0; i < 40 && !sd; i++) begin
            if (m1_write && m1_address == 32'd20) sd = 1;
            else tick();
        end
        check("abort_reached_lane10", sd, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_until_end(20, sd, se);
        check("abort_done", sd, 1);
        check("abort_written", written, 11);
        check("abort_nwrites", log_addr.size() - run_base, 11);
        check("abort_last_addr", log_addr[run_base+10], 32'd20);
        repeat (3) tick();
        check("abort_no_more", log_addr.size() - run_base, 11);
        special_idx = -1;

        // asynchronous reset mid-run
        stall_default = 3;
        start_run(32'h0, 0, 0, 50, 0, 16'h0);
        repeat (4) tick();
        check("rst_pre_write", m1_write, 1);
        reset_n = 1'b0;
        #1;
        check("rst_async_write", m1_write, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_written", written, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_idle", busy, 0);
        stall_default = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
